// File: rtl/uart_apb_regfile_if.sv
// APB-side access bundle for uart_apb_regfile: one-cycle strobes in, registered response out.
interface uart_apb_regfile_if #(parameter int ADDR_WD = 12);
  logic [ADDR_WD-1:0] apb_addr;
  logic               apb_read_en;
  logic               apb_write_en;
  logic [31:0]        apb_wdata;
  logic [31:0]        apb_rdata;
  logic               apb_slverr;

  modport master (output apb_addr, apb_read_en, apb_write_en, apb_wdata,
                  input  apb_rdata, apb_slverr);
  modport slave  (input  apb_addr, apb_read_en, apb_write_en, apb_wdata,
                  output apb_rdata, apb_slverr);
endinterface

// File: rtl/uart_apb_regfile.sv
// UART programming model: config regs, sticky W1C status, IRQ, TX/RX FIFO strobes.
// Optional DMA request generation under `define UART_REGS_DMA_EN.
module uart_apb_regfile #(
  parameter int          ADDR_WD      = 12,
  parameter int          TX_FIFO_DPL2 = 3,
  parameter int          RX_FIFO_DPL2 = 3,
  parameter logic [31:0] VERSION      = 32'h0002_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_apb_regfile_if.slave     apb,
  input  logic                  evt_pe,
  input  logic                  evt_fe,
  input  logic                  evt_ne,
  input  logic                  evt_ore,
  input  logic                  evt_idle,
  input  logic [TX_FIFO_DPL2:0] tx_lvl,
  input  logic [RX_FIFO_DPL2:0] rx_lvl,
  input  logic                  tx_busy,
  output logic                  txd_push,
  output logic [8:0]            txd_data,
  output logic                  rxd_pop,
  input  logic [8:0]            rxd_data,
  output logic [11:0]           br_mantissa,
  output logic [3:0]            br_fraction,
  output logic                  cr_re,
  output logic                  cr_te,
  output logic                  cr_ps,
  output logic                  cr_pce,
  output logic                  cr_wdlen,
  output logic [1:0]            cr_stoplen,
  output logic [TX_FIFO_DPL2:0] tfifo_wk,
  output logic [RX_FIFO_DPL2:0] rfifo_wk,
  output logic                  irq,
  output logic                  dma_tx_req,
  output logic                  dma_rx_req
);
  localparam int TL = TX_FIFO_DPL2 + 1;
  localparam int RL = RX_FIFO_DPL2 + 1;
  localparam logic [TL:0] DT = (TL+1)'(2**TX_FIFO_DPL2);
  localparam logic [11:0] STICKY_M = 12'hC1F;

  localparam logic [ADDR_WD-1:0] A_VERID = ADDR_WD'('h00);
  localparam logic [ADDR_WD-1:0] A_SR    = ADDR_WD'('h04);
  localparam logic [ADDR_WD-1:0] A_TDR   = ADDR_WD'('h08);
  localparam logic [ADDR_WD-1:0] A_RDR   = ADDR_WD'('h0C);
  localparam logic [ADDR_WD-1:0] A_BRR   = ADDR_WD'('h10);
  localparam logic [ADDR_WD-1:0] A_CR    = ADDR_WD'('h14);
  localparam logic [ADDR_WD-1:0] A_IER   = ADDR_WD'('h1C);
  localparam logic [ADDR_WD-1:0] A_TFIFO = ADDR_WD'('h20);
  localparam logic [ADDR_WD-1:0] A_RFIFO = ADDR_WD'('h24);
  localparam logic [ADDR_WD-1:0] A_ISR   = ADDR_WD'('h28);

  logic [15:0]   br_q, br_d;
  logic [6:0]    cr_q, cr_d;
  logic [1:0]    dmacr_q, dmacr_d;
  logic [11:0]   ier_q, ier_d;
  logic [TL-1:0] tfwk_q, tfwk_d;
  logic [RL-1:0] rfwk_q, rfwk_d;
  logic [11:0]   sticky_q, sticky_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          slverr_q, slverr_d;
  logic          txd_push_q, txd_push_d;
  logic [8:0]    txd_data_q, txd_data_d;
  logic          rxd_pop_q, rxd_pop_d;
  logic          irq_q, irq_d;

  logic [ADDR_WD-1:0] addr;
  logic [31:0]        wdata;
  logic rd, wr, both, mapped, ro, acc_err, rd_ok, wr_ok;
  logic h_verid, h_sr, h_tdr, h_rdr, h_brr, h_cr, h_dmacr, h_ier, h_tfifo, h_rfifo, h_isr;
  logic rxne, tc, txe, tfwk, rfwk, tx_room, rx_avail, tfov_set, rfud_set;
  logic [11:0] live, sr_cur, w1c;
  logic unused_wdata;

  assign addr         = apb.apb_addr;
  assign wdata        = apb.apb_wdata;
  assign unused_wdata = ^wdata[31:16];

  assign rd   = apb.apb_read_en & ~apb.apb_write_en;
  assign wr   = apb.apb_write_en & ~apb.apb_read_en;
  assign both = apb.apb_read_en & apb.apb_write_en;

  assign h_verid = (addr == A_VERID);
  assign h_sr    = (addr == A_SR);
  assign h_tdr   = (addr == A_TDR);
  assign h_rdr   = (addr == A_RDR);
  assign h_brr   = (addr == A_BRR);
  assign h_cr    = (addr == A_CR);
  assign h_ier   = (addr == A_IER);
  assign h_tfifo = (addr == A_TFIFO);
  assign h_rfifo = (addr == A_RFIFO);
  assign h_isr   = (addr == A_ISR);

  assign mapped  = h_verid | h_sr | h_tdr | h_rdr | h_brr | h_cr | h_dmacr |
                   h_ier | h_tfifo | h_rfifo | h_isr;
  assign ro      = h_verid | h_rdr | h_isr;
  assign acc_err = both | ((rd | wr) & ~mapped) | (wr & ro);
  assign rd_ok   = rd & mapped;
  assign wr_ok   = wr & mapped & ~ro;

  assign rxne   = (rx_lvl != '0);
  assign tc     = (tx_lvl == '0) & ~tx_busy;
  assign txe    = ({1'b0, tx_lvl} < DT);
  assign tfwk   = (tx_lvl <= tfwk_q);
  assign rfwk   = (rx_lvl >= rfwk_q);
  assign live   = {2'b00, rfwk, tfwk, txe, tc, rxne, 5'b0};
  assign sr_cur = sticky_q | live;

  // A strobe issued last cycle is not yet visible in the level inputs.
  assign tx_room  = ({1'b0, tx_lvl} + {{TL{1'b0}}, txd_push_q}) < DT;
  assign rx_avail = rx_lvl > {{(RL-1){1'b0}}, rxd_pop_q};

  always_comb begin
    br_d       = br_q;
    cr_d       = cr_q;
    dmacr_d    = dmacr_q;
    ier_d      = ier_q;
    tfwk_d     = tfwk_q;
    rfwk_d     = rfwk_q;
    rdata_d    = rdata_q;
    slverr_d   = slverr_q;
    txd_push_d = 1'b0;
    txd_data_d = txd_data_q;
    rxd_pop_d  = 1'b0;
    tfov_set   = 1'b0;
    rfud_set   = 1'b0;
    w1c        = '0;

    if (rd | wr | both) begin
      slverr_d = acc_err;
      rdata_d  = '0;
    end

    if (wr_ok) begin
      if (h_sr) w1c = wdata[11:0] & STICKY_M;
      if (h_tdr) begin
        if (tx_room) begin
          txd_push_d = 1'b1;
          txd_data_d = wdata[8:0];
        end else begin
          tfov_set = 1'b1;
        end
      end
      if (h_brr)   br_d    = wdata[15:0];
      if (h_cr)    cr_d    = wdata[6:0];
      if (h_dmacr) dmacr_d = wdata[1:0];
      if (h_ier)   ier_d   = wdata[11:0];
      if (h_tfifo) tfwk_d  = wdata[TL-1:0];
      if (h_rfifo) rfwk_d  = wdata[RL-1:0];
    end

    if (rd_ok) begin
      if (h_verid) rdata_d = VERSION;
      if (h_sr)    rdata_d = {20'b0, sr_cur};
      if (h_rdr) begin
        if (rx_avail) begin
          rdata_d   = {23'b0, rxd_data};
          rxd_pop_d = 1'b1;
        end else begin
          rfud_set = 1'b1;
        end
      end
      if (h_brr)   rdata_d = {16'b0, br_q};
      if (h_cr)    rdata_d = {25'b0, cr_q};
      if (h_dmacr) rdata_d = {30'b0, dmacr_q};
      if (h_ier)   rdata_d = {20'b0, ier_q};
      if (h_tfifo) rdata_d = {{(32-TL){1'b0}}, tfwk_q};
      if (h_rfifo) rdata_d = {{(32-RL){1'b0}}, rfwk_q};
      if (h_isr)   rdata_d = {20'b0, sr_cur & ier_q};
    end

    // Set beats clear when an event lands on the same edge as its W1C.
    sticky_d = (sticky_q & ~w1c) |
               {rfud_set, tfov_set, 5'b0, evt_idle, evt_ore, evt_ne, evt_fe, evt_pe};
    irq_d    = |((sticky_d | live) & ier_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q       <= '0;
      cr_q       <= '0;
      dmacr_q    <= '0;
      ier_q      <= '0;
      tfwk_q     <= '0;
      rfwk_q     <= RL'(1);
      sticky_q   <= '0;
      rdata_q    <= '0;
      slverr_q   <= 1'b0;
      txd_push_q <= 1'b0;
      txd_data_q <= '0;
      rxd_pop_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      br_q       <= br_d;
      cr_q       <= cr_d;
      dmacr_q    <= dmacr_d;
      ier_q      <= ier_d;
      tfwk_q     <= tfwk_d;
      rfwk_q     <= rfwk_d;
      sticky_q   <= sticky_d;
      rdata_q    <= rdata_d;
      slverr_q   <= slverr_d;
      txd_push_q <= txd_push_d;
      txd_data_q <= txd_data_d;
      rxd_pop_q  <= rxd_pop_d;
      irq_q      <= irq_d;
    end
  end

`ifdef UART_REGS_DMA_EN
  localparam logic [ADDR_WD-1:0] A_DMACR = ADDR_WD'('h18);
  logic dma_tx_q, dma_rx_q;

  assign h_dmacr = (addr == A_DMACR);

  // Gating on the strobe gives the FIFO level one cycle to catch up per transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_tx_q <= 1'b0;
      dma_rx_q <= 1'b0;
    end else begin
      dma_tx_q <= dmacr_q[0] & txe & ~txd_push_q;
      dma_rx_q <= dmacr_q[1] & rxne & ~rxd_pop_q;
    end
  end

  assign dma_tx_req = dma_tx_q;
  assign dma_rx_req = dma_rx_q;
`else
  assign h_dmacr    = 1'b0;
  assign dma_tx_req = 1'b0;
  assign dma_rx_req = 1'b0;
`endif

  assign apb.apb_rdata  = rdata_q;
  assign apb.apb_slverr = slverr_q;
  assign txd_push       = txd_push_q;
  assign txd_data       = txd_data_q;
  assign rxd_pop        = rxd_pop_q;
  assign br_mantissa    = br_q[15:4];
  assign br_fraction    = br_q[3:0];
  assign cr_re          = cr_q[0];
  assign cr_te          = cr_q[1];
  assign cr_ps          = cr_q[2];
  assign cr_pce         = cr_q[3];
  assign cr_wdlen       = cr_q[4];
  assign cr_stoplen     = cr_q[6:5];
  assign tfifo_wk       = tfwk_q;
  assign rfifo_wk       = rfwk_q;
  assign irq            = irq_q;
endmodule

// File: tb/tb_uart_apb_regfile.sv
// Self-checking bench for uart_apb_regfile: vector table, directed corner sequences,
// then randomized traffic against a behavioural register-map model.
module tb_uart_apb_regfile;
`ifdef UART_REGS_DMA_EN
  localparam bit DMA_ON = 1'b1;
`else
  localparam bit DMA_ON = 1'b0;
`endif
  localparam logic [31:0] VER = 32'h0002_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic evt_pe = 0, evt_fe = 0, evt_ne = 0, evt_ore = 0, evt_idle = 0;
  logic [3:0] tx_lvl = 0, rx_lvl = 0;
  logic tx_busy = 0;
  logic txd_push, rxd_pop, irq, dma_tx_req, dma_rx_req;
  logic [8:0] txd_data, rxd_data = 0;
  logic [11:0] br_mantissa;
  logic [3:0] br_fraction, tfifo_wk, rfifo_wk;
  logic cr_re, cr_te, cr_ps, cr_pce, cr_wdlen;
  logic [1:0] cr_stoplen;

  int n_cmp = 0, n_bad = 0;

  uart_apb_regfile_if #(.ADDR_WD(12)) apb_if ();

  uart_apb_regfile #(.ADDR_WD(12), .TX_FIFO_DPL2(3), .RX_FIFO_DPL2(3), .VERSION(VER)) dut (
    .clk(clk), .rst_n(rst_n), .apb(apb_if),
    .evt_pe(evt_pe), .evt_fe(evt_fe), .evt_ne(evt_ne), .evt_ore(evt_ore), .evt_idle(evt_idle),
    .tx_lvl(tx_lvl), .rx_lvl(rx_lvl), .tx_busy(tx_busy),
    .txd_push(txd_push), .txd_data(txd_data), .rxd_pop(rxd_pop), .rxd_data(rxd_data),
    .br_mantissa(br_mantissa), .br_fraction(br_fraction),
    .cr_re(cr_re), .cr_te(cr_te), .cr_ps(cr_ps), .cr_pce(cr_pce), .cr_wdlen(cr_wdlen),
    .cr_stoplen(cr_stoplen), .tfifo_wk(tfifo_wk), .rfifo_wk(rfifo_wk),
    .irq(irq), .dma_tx_req(dma_tx_req), .dma_rx_req(dma_rx_req));

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t v(bit rd, bit wr, logic [11:0] a, logic [31:0] wd,
                             logic [31:0] er, bit ee);
    vec_t x;
    x.rd = rd; x.wr = wr; x.addr = a; x.wd = wd; x.exp_rdata = er; x.exp_err = ee;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input bit rd, input bit wr, input logic [11:0] a, input logic [31:0] wd);
    apb_if.apb_addr     = a;
    apb_if.apb_wdata    = wd;
    apb_if.apb_read_en  = rd;
    apb_if.apb_write_en = wr;
    cyc();
    apb_if.apb_read_en  = 1'b0;
    apb_if.apb_write_en = 1'b0;
  endtask

  // ---- behavioural model of the register map ----
  logic [15:0] m_br;
  logic [6:0]  m_cr;
  logic [1:0]  m_dma;
  logic [11:0] m_ier, m_sticky;
  logic [3:0]  m_tfwk, m_rfwk;
  logic [31:0] m_rdata;
  logic [8:0]  m_txd;
  bit m_err, m_push, m_pop, m_irq, m_dtx, m_drx;

  task automatic model_reset();
    m_br = 0; m_cr = 0; m_dma = 0; m_ier = 0; m_sticky = 0; m_tfwk = 0; m_rfwk = 1;
    m_rdata = 0; m_txd = 0; m_err = 0; m_push = 0; m_pop = 0; m_irq = 0; m_dtx = 0; m_drx = 0;
  endtask

  function automatic logic [11:0] live_bits();
    logic [11:0] l = '0;
    l[5] = (rx_lvl != 0);
    l[6] = (tx_lvl == 0) && !tx_busy;
    l[7] = (int'(tx_lvl) < 8);
    l[8] = (tx_lvl <= m_tfwk);
    l[9] = (rx_lvl >= m_rfwk);
    return l;
  endfunction

  // Called with inputs stable, before the edge; leaves the post-edge expectations.
  task automatic model_cycle(input bit rd, input bit wr, input logic [11:0] a, input logic [31:0] wd);
    logic [11:0] lv, sr, set, clr;
    bit mapped, ro, err, push_now, pop_now;
    lv = live_bits();
    sr = m_sticky | lv;
    set = '0; clr = '0; push_now = 0; pop_now = 0;
    set[0] = evt_pe; set[1] = evt_fe; set[2] = evt_ne; set[3] = evt_ore; set[4] = evt_idle;
    if (rd || wr) begin
      mapped = (a inside {12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                          12'h01C, 12'h020, 12'h024, 12'h028}) || (a == 12'h018 && DMA_ON);
      ro  = a inside {12'h000, 12'h00C, 12'h028};
      err = (rd && wr) || !mapped || (wr && ro);
      m_err = err; m_rdata = 0;
      if (!err && rd) begin
        case (a)
          12'h000: m_rdata = VER;
          12'h004: m_rdata = {20'b0, sr};
          12'h00C: if (int'(rx_lvl) - int'(m_pop) > 0) begin
                     m_rdata = {23'b0, rxd_data}; pop_now = 1;
                   end else set[11] = 1;
          12'h010: m_rdata = {16'b0, m_br};
          12'h014: m_rdata = {25'b0, m_cr};
          12'h018: m_rdata = {30'b0, m_dma};
          12'h01C: m_rdata = {20'b0, m_ier};
          12'h020: m_rdata = {28'b0, m_tfwk};
          12'h024: m_rdata = {28'b0, m_rfwk};
          12'h028: m_rdata = {20'b0, sr & m_ier};
          default: m_rdata = 0;
        endcase
      end
      if (!err && wr) begin
        case (a)
          12'h004: clr = wd[11:0] & 12'hC1F;
          12'h008: if (int'(tx_lvl) + int'(m_push) < 8) begin
                     push_now = 1; m_txd = wd[8:0];
                   end else set[10] = 1;
          12'h010: m_br = wd[15:0];
          12'h014: m_cr = wd[6:0];
          12'h018: m_dma = wd[1:0];
          12'h01C: m_ier = wd[11:0];
          12'h020: m_tfwk = wd[3:0];
          12'h024: m_rfwk = wd[3:0];
          default: ;
        endcase
      end
    end
    m_sticky = (m_sticky & ~clr) | set;
    m_irq = |((m_sticky | lv) & m_ier);
    m_dtx = DMA_ON && m_dma[0] && lv[7] && !m_push;
    m_drx = DMA_ON && m_dma[1] && lv[5] && !m_pop;
    m_push = push_now;
    m_pop = pop_now;
  endtask

  logic [11:0] amap [12] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                             12'h018, 12'h01C, 12'h020, 12'h024, 12'h028, 12'h030};

  initial begin
    apb_if.apb_addr = 0; apb_if.apb_wdata = 0;
    apb_if.apb_read_en = 0; apb_if.apb_write_en = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", apb_if.apb_rdata, 0);
    chk("rst_slverr", apb_if.apb_slverr, 0);
    chk("rst_strobes", {txd_push, rxd_pop, irq, dma_tx_req, dma_rx_req}, 0);
    chk("rst_cfg", {br_mantissa, br_fraction, cr_stoplen, cr_wdlen, cr_pce, cr_ps, cr_te, cr_re}, 0);
    chk("rst_wk", {tfifo_wk, rfifo_wk}, 8'h01);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // table: reset readback, config writes, error cases
    vt.push_back(v(1, 0, 12'h000, 0, VER, 0));
    vt.push_back(v(1, 0, 12'h004, 0, 32'h1C0, 0));
    vt.push_back(v(1, 0, 12'h008, 0, 0, 0));
    vt.push_back(v(1, 0, 12'h010, 0, 0, 0));
    vt.push_back(v(1, 0, 12'h014, 0, 0, 0));
    vt.push_back(v(1, 0, 12'h018, 0, 0, !DMA_ON));
    vt.push_back(v(1, 0, 12'h01C, 0, 0, 0));
    vt.push_back(v(1, 0, 12'h020, 0, 0, 0));
    vt.push_back(v(1, 0, 12'h024, 0, 1, 0));
    vt.push_back(v(1, 0, 12'h028, 0, 0, 0));
    vt.push_back(v(0, 1, 12'h010, 32'h1234_5678, 0, 0));
    vt.push_back(v(1, 0, 12'h010, 0, 32'h5678, 0));
    vt.push_back(v(0, 1, 12'h014, 32'hFFFF_FF55, 0, 0));
    vt.push_back(v(1, 0, 12'h014, 0, 32'h55, 0));
    vt.push_back(v(0, 1, 12'h020, 32'h3A, 0, 0));
    vt.push_back(v(1, 0, 12'h020, 0, 32'hA, 0));
    vt.push_back(v(0, 1, 12'h024, 32'h3, 0, 0));
    vt.push_back(v(1, 0, 12'h024, 0, 32'h3, 0));
    vt.push_back(v(0, 1, 12'h000, 32'h1, 0, 1));
    vt.push_back(v(0, 1, 12'h00C, 32'h1, 0, 1));
    vt.push_back(v(0, 1, 12'h028, 32'h1, 0, 1));
    vt.push_back(v(1, 0, 12'h030, 0, 0, 1));
    vt.push_back(v(0, 1, 12'h02C, 32'hFFFF, 0, 1));
    vt.push_back(v(1, 0, 12'h002, 0, 0, 1));
    vt.push_back(v(0, 1, 12'h004, 32'hFFF, 0, 0));
    vt.push_back(v(1, 0, 12'h004, 0, 32'h1C0, 0));
    vt.push_back(v(1, 0, 12'h010, 0, 32'h5678, 0));
    vt.push_back(v(1, 0, 12'h000, 0, VER, 0));
    foreach (vt[i]) begin
      acc(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd);
      chk($sformatf("vec%0d_rdata", i), apb_if.apb_rdata, vt[i].exp_rdata);
      chk($sformatf("vec%0d_slverr", i), apb_if.apb_slverr, vt[i].exp_err);
    end
    chk("cfg_br", {br_mantissa, br_fraction}, 16'h5678);
    chk("cfg_cr", {cr_stoplen, cr_wdlen, cr_pce, cr_ps, cr_te, cr_re}, 7'h55);
    chk("cfg_wk", {tfifo_wk, rfifo_wk}, 8'hA3);

    // TDR back-to-back into DT-1
    tx_lvl = 7;
    acc(0, 1, 12'h008, 32'h1A5);
    chk("tdr1_push", {txd_push, txd_data}, {1'b1, 9'h1A5});
    acc(0, 1, 12'h008, 32'h1A5);
    chk("tdr2_nopush", txd_push, 0);
    cyc();
    chk("tdr_idle_nopush", txd_push, 0);
    acc(1, 0, 12'h004, 0);
    chk("tfov_set", apb_if.apb_rdata[10], 1);
    acc(0, 1, 12'h004, 32'h400);
    acc(1, 0, 12'h004, 0);
    chk("tfov_clr", apb_if.apb_rdata[10], 0);
    tx_lvl = 0;

    // RDR empty / non-empty / back-to-back / dual strobe
    rx_lvl = 0;
    acc(1, 0, 12'h00C, 0);
    chk("rdr_empty_rdata", apb_if.apb_rdata, 0);
    chk("rdr_empty_pop", {rxd_pop, apb_if.apb_slverr}, 0);
    acc(1, 0, 12'h004, 0);
    chk("rfud_set", apb_if.apb_rdata[11], 1);
    rx_lvl = 2; rxd_data = 9'h055;
    acc(1, 0, 12'h00C, 0);
    chk("rdr_rdata", apb_if.apb_rdata, 32'h55);
    chk("rdr_pop", rxd_pop, 1);
    cyc();
    chk("rdr_pop_once", rxd_pop, 0);
    rx_lvl = 1;
    acc(1, 0, 12'h00C, 0);
    chk("rdr_b2b1_pop", rxd_pop, 1);
    acc(1, 0, 12'h00C, 0);
    chk("rdr_b2b2", {rxd_pop, apb_if.apb_rdata}, 33'h0);
    rx_lvl = 2;
    acc(1, 1, 12'h00C, 0);
    chk("dual_err", {apb_if.apb_slverr, rxd_pop, apb_if.apb_rdata}, {1'b1, 33'h0});
    rx_lvl = 0;

    // IRQ on fe, set-wins-over-clear, W1C drop
    acc(0, 1, 12'h004, 32'hFFF);
    acc(0, 1, 12'h01C, 32'h002);
    chk("irq_idle", irq, 0);
    evt_fe = 1; cyc(); evt_fe = 0;
    chk("irq_rise", irq, 1);
    evt_fe = 1; acc(0, 1, 12'h004, 32'h002); evt_fe = 0;
    chk("irq_setwins", irq, 1);
    acc(1, 0, 12'h004, 0);
    chk("fe_setwins", apb_if.apb_rdata[1], 1);
    acc(0, 1, 12'h004, 32'h002);
    chk("irq_fall", irq, 0);
    acc(0, 1, 12'h01C, 0);

    // DMA request
`ifdef UART_REGS_DMA_EN
    tx_lvl = 0;
    acc(0, 1, 12'h018, 32'h1);
    cyc(); cyc();
    chk("dma_tx_on", {dma_tx_req, dma_rx_req}, 2'b10);
    acc(0, 1, 12'h008, 32'h0AB);
    chk("dma_push_cyc", {txd_push, dma_tx_req}, 2'b11);
    cyc();
    chk("dma_gap", dma_tx_req, 0);
    cyc();
    chk("dma_back", dma_tx_req, 1);
    acc(0, 1, 12'h018, 32'h0);
`else
    acc(0, 1, 12'h018, 32'h3);
    cyc(); cyc();
    chk("dma_off", {dma_tx_req, dma_rx_req, apb_if.apb_slverr}, 3'b001);
`endif

    // reset mid-access drops the pending push
    tx_lvl = 0;
    apb_if.apb_addr = 12'h008; apb_if.apb_wdata = 32'h11; apb_if.apb_write_en = 1;
    cyc();
    apb_if.apb_write_en = 0;
    chk("pre_rst_push", txd_push, 1);
    rst_n = 0;
    #1;
    chk("rst_async", {txd_push, irq, br_mantissa, rfifo_wk}, {2'b00, 12'h000, 4'h1});
    @(negedge clk) rst_n = 1;
    cyc();

    // randomized traffic vs model
    model_reset();
    for (int it = 0; it < 400; it++) begin
      int k;
      bit r, w;
      logic [11:0] a;
      logic [31:0] wd;
      tx_lvl = 4'($urandom_range(0, 8));
      rx_lvl = 4'($urandom_range(0, 8));
      tx_busy = 1'($urandom);
      rxd_data = 9'($urandom);
      evt_pe = ($urandom_range(0, 7) == 0); evt_fe = ($urandom_range(0, 7) == 0);
      evt_ne = ($urandom_range(0, 7) == 0); evt_ore = ($urandom_range(0, 7) == 0);
      evt_idle = ($urandom_range(0, 7) == 0);
      k = $urandom_range(0, 9);
      r = (k < 4) || (k == 8);
      w = (k >= 4 && k < 8) || (k == 8);
      a = amap[$urandom_range(0, 11)];
      wd = $urandom;
      apb_if.apb_addr = a; apb_if.apb_wdata = wd;
      apb_if.apb_read_en = r; apb_if.apb_write_en = w;
      model_cycle(r, w, a, wd);
      cyc();
      apb_if.apb_read_en = 0; apb_if.apb_write_en = 0;
      evt_pe = 0; evt_fe = 0; evt_ne = 0; evt_ore = 0; evt_idle = 0;
      chk($sformatf("rnd%0d_rdata", it), apb_if.apb_rdata, m_rdata);
      chk($sformatf("rnd%0d_slverr", it), apb_if.apb_slverr, m_err);
      chk($sformatf("rnd%0d_irq", it), irq, m_irq);
      chk($sformatf("rnd%0d_push_pop", it), {txd_push, rxd_pop}, {m_push, m_pop});
      if (m_push) chk($sformatf("rnd%0d_txd", it), txd_data, m_txd);
      chk($sformatf("rnd%0d_dma", it), {dma_tx_req, dma_rx_req}, {m_dtx, m_drx});
    end
    chk("rnd_cfg", {br_mantissa, br_fraction, cr_stoplen, cr_wdlen, cr_pce, cr_ps, cr_te, cr_re},
        {m_br, m_cr});
    chk("rnd_wk", {tfifo_wk, rfifo_wk}, {m_tfwk, m_rfwk});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
